// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes, FSM state encoding, BCD digit type and the
// row/column helpers shared by the membrane keypad scanner.
package keypad_pkg;

  // One decimal digit of the entry register (always held in 0-9).
  typedef logic [3:0] bcd_t;

  // Non-numeric key codes; digits 0-9 use their own value.
  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  // Scanner FSM states.
  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_PRESS_DB = 2'd1;
  localparam logic [1:0] ST_HOLD     = 2'd2;
  localparam logic [1:0] ST_REL_DB   = 2'd3;

  // Lowest-index column that is pulled low (columns are active-low).
  function automatic logic [1:0] lowest_low_col(input logic [3:0] cols);
    logic [1:0] idx;
    idx = 2'd0;
    if (!cols[0])      idx = 2'd0;
    else if (!cols[1]) idx = 2'd1;
    else if (!cols[2]) idx = 2'd2;
    else if (!cols[3]) idx = 2'd3;
    return idx;
  endfunction

  // Physical key position to key code.
  function automatic logic [3:0] key_code_of(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd2;
      4'b00_10: code = 4'd3;
      4'b00_11: code = KEY_A;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b01_11: code = KEY_B;
      4'b10_00: code = 4'd7;
      4'b10_01: code = 4'd8;
      4'b10_10: code = 4'd9;
      4'b10_11: code = KEY_C;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = 4'd0;
      4'b11_10: code = KEY_HASH;
      default:  code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: counts consecutive cycles of 'match'. 'stable' is high in
// the cycle the count reaches CYCLES. Any mismatch or 'start' clears the count.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned CYCLES = 50000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start,
  input  logic match,
  output logic stable
);

  localparam int unsigned CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear on start or mismatch, otherwise saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (start || !match) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(CYCLES)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Stable-count register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign stable = !start && match && (cnt_q == CW'(CYCLES - 1));

endmodule

// File: rtl/membrana_keypad.sv
// membrana_keypad: 4x4 membrane keypad scanner with debounced key decode and
// a 4-digit BCD entry register. Optional build macro KEYPAD_BACKSPACE_EN makes
// key D a backspace (shift right) when unlocked.
module membrana_keypad
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] cols,
  input  logic       lock,
  output logic [3:0] rows,
  output logic [3:0] m,
  output logic [3:0] c,
  output logic [3:0] d,
  output logic [3:0] u,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       done
);

  localparam int unsigned SW = $clog2(SCAN_DIV);

  logic [3:0]    sync_q, cs_q;
  logic [1:0]    state_q, state_d;
  logic [1:0]    row_q, row_d;
  logic [1:0]    col_q, col_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  bcd_t          m_q, m_d, c_q, c_d, d_q, d_d, u_q, u_d;
  logic          key_valid_q, key_valid_d;
  logic          done_q, done_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          db_start, db_match, db_stable;
  logic          fire;
  logic [3:0]    hit_code;

  // Two-flop synchroniser on the asynchronous columns; idle level is all-high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 4'hF;
      cs_q   <= 4'hF;
    end else begin
      sync_q <= cols;
      cs_q   <= sync_q;
    end
  end

  // One counter serves both debounce phases: press watches the latched column,
  // release watches for all columns high.
  assign db_start = (state_q == ST_SCAN) || (state_q == ST_HOLD);
  assign db_match = (state_q == ST_PRESS_DB) ? ~cs_q[col_q] : (cs_q == 4'hF);
  assign hit_code = key_code_of(row_q, col_q);

  keypad_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (db_start),
    .match   (db_match),
    .stable  (db_stable)
  );

  // Scanner FSM: row stepping, key latch, press/release debounce sequencing.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    scan_cnt_d = scan_cnt_q;
    fire       = 1'b0;
    case (state_q)
      ST_SCAN: begin
        if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
          scan_cnt_d = '0;
          if (cs_q != 4'hF) begin
            col_d   = lowest_low_col(cs_q);
            state_d = ST_PRESS_DB;
          end else begin
            row_d = row_q + 2'd1;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + SW'(1);
        end
      end
      ST_PRESS_DB: begin
        if (!db_match) begin
          state_d = ST_SCAN;
          row_d   = row_q + 2'd1;
        end else if (db_stable) begin
          fire    = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cs_q == 4'hF) state_d = ST_REL_DB;
      end
      ST_REL_DB: begin
        if (!db_match) begin
          state_d = ST_HOLD;
        end else if (db_stable) begin
          state_d = ST_SCAN;
          row_d   = 2'd0;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  // Key action: pulses, code capture and entry-register update.
  always_comb begin
    key_valid_d = 1'b0;
    done_d      = 1'b0;
    key_code_d  = key_code_q;
    m_d         = m_q;
    c_d         = c_q;
    d_d         = d_q;
    u_d         = u_q;
    if (fire) begin
      key_valid_d = 1'b1;
      key_code_d  = hit_code;
      done_d      = (hit_code == KEY_HASH);
      if (!lock) begin
        if (hit_code <= 4'd9) begin
          m_d = c_q;
          c_d = d_q;
          d_d = u_q;
          u_d = hit_code;
        end else if (hit_code == KEY_STAR) begin
          m_d = '0;
          c_d = '0;
          d_d = '0;
          u_d = '0;
        end
`ifdef KEYPAD_BACKSPACE_EN
        else if (hit_code == KEY_D) begin
          u_d = d_q;
          d_d = c_q;
          c_d = m_q;
          m_d = '0;
        end
`endif
      end
    end
  end

  // State, scan and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_SCAN;
      row_q       <= 2'd0;
      col_q       <= 2'd0;
      scan_cnt_q  <= '0;
      m_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      u_q         <= '0;
      key_valid_q <= 1'b0;
      done_q      <= 1'b0;
      key_code_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      scan_cnt_q  <= scan_cnt_d;
      m_q         <= m_d;
      c_q         <= c_d;
      d_q         <= d_d;
      u_q         <= u_d;
      key_valid_q <= key_valid_d;
      done_q      <= done_d;
      key_code_q  <= key_code_d;
    end
  end

  assign rows      = ~(4'b0001 << row_q);
  assign m         = m_q;
  assign c         = c_q;
  assign d         = d_q;
  assign u         = u_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign done      = done_q;

endmodule

// File: doc/membrana_keypad.md
# membrana_keypad

Scanner and entry register for the 4x4 membrane keypad. It drives the keypad rows, synchronises and debounces the columns, and decodes each accepted key. Numeric keys shift into a 4-digit BCD entry register whose outputs feed the `m`/`c`/`d`/`u` inputs of `display`. An enter key produces a one-cycle `done` pulse that the control logic uses to latch the typed value.

## Interface
- `SCAN_DIV`, 1000: cycles each row is held low before its columns are sampled; minimum 4.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles required to accept a press or a release; minimum 2.
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cols`  in  4  keypad columns, active-low, pulled up externally, asynchronous to `clock`.
- `lock`  in  1  when 1, digit and clear keys do not modify the entry register.
- `rows`  out  4  row drive, one-hot-low.
- `m`, `c`, `d`, `u`  out  4 each  BCD thousands/hundreds/tens/units of the entry.
- `key_valid`  out  1  one-cycle pulse per accepted key.
- `key_code`  out  4  code of the last accepted key.
- `done`  out  1  one-cycle pulse on enter.

## Operation
- Key map (row, col):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: `*` 0 `#` D
- Codes: digits 0-9 map to their value; A=10, B=11, C=12, D=13, `*`=14, `#`=15.
- Columns pass through a 2-flop synchroniser; all logic uses the synchronised value `cs`.
- FSM states:
  - SCAN: the row pointer advances 0→1→2→3→0 every `SCAN_DIV` cycles. In the last cycle of each dwell, if `cs != 4'b1111`, latch the row and the lowest-index low column, freeze `rows`, and go to PRESS_DB.
  - PRESS_DB: the counter increments while the latched column stays low. If it goes high before the count completes, clear the counter and return to SCAN at the next row. When the counter reaches `DEBOUNCE_CYCLES`, perform the key action and go to HOLD.
  - HOLD: wait until `cs == 4'b1111`, then go to REL_DB.
  - REL_DB: requires `DEBOUNCE_CYCLES` consecutive all-high cycles; any low column returns the FSM to HOLD. On completion, return to SCAN at row 0.
- Key actions (all take effect in the same cycle as the `key_valid` pulse):
  - Digit, `lock=0`: shift left; `m<=c`, `c<=d`, `d<=u`, `u<=digit`. The old `m` is discarded.
  - `*`, `lock=0`: `m`, `c`, `d`, `u` all set to 0.
  - `#`: `done=1` for one cycle; the entry register is unchanged, independent of `lock`.
  - A/B/C: only `key_valid` and `key_code` update.
  - With `lock=1`, digit and `*` keys still update `key_valid` and `key_code`.
- Simultaneous keys: only the latched key counts until release. A second key pressed during HOLD extends HOLD and is never reported.
- The entry register always holds BCD 0-9 per digit; no binary arithmetic is performed.

## Timing
- Reset values:
  - `rows=4'b1110`, scan pointer at row 0, state SCAN, all counters 0.
  - `m=c=d=u=0`, `key_valid=0`, `key_code=0`, `done=0`.
- Reset mid-operation returns everything to these values immediately. Any press in progress is lost.
- Press latency: the action occurs `DEBOUNCE_CYCLES` cycles after the detection cycle. The detection cycle itself is up to `SCAN_DIV` cycles, plus 2 synchroniser cycles, after the column edge.
- `m`/`c`/`d`/`u` change only in the `key_valid` cycle and are stable otherwise.
- `key_valid` and `done` are registered single-cycle pulses; at most one `key_valid` per press/release cycle.

## Configuration
- `KEYPAD_BACKSPACE_EN` defined: key D acts as backspace when `lock=0`; `u<=d`, `d<=c`, `c<=m`, `m<=0`.
- Not defined: D behaves like A/B/C (reports `key_code=13` only).

## Structure
- Shared package `keypad_pkg`: key code constants, FSM state encoding, and the 7-segment-independent BCD digit type.
- One sub-module, `keypad_debounce`: stable-count counter with a `match` input, a `start` clear and a `stable` output. It is reused for both press and release debouncing.

## Test plan
Bench parameters: `SCAN_DIV=4`, `DEBOUNCE_CYCLES=8`.
- Reset, press `1`,`2`,`3`,`4` in turn with full release between presses → `m,c,d,u = 1,2,3,4`; four `key_valid` pulses; `key_code` ends at 4.
- Press `5` after that entry → `m,c,d,u = 2,3,4,5`; then `*` → `0,0,0,0`.
- Bounce `cols[1]` low for 3 cycles during r0 → no `key_valid`; scan resumes at r1.
- Hold `7` (r2c0) and `8` (r2c1) together → only code 7 accepted; releasing 7 while 8 stays pressed produces no second pulse.
- `lock=1`, press `9` → `key_valid=1` with `key_code=9`, entry unchanged; press `#` → `done` pulses for exactly one cycle.
- Assert `reset_n=0` during PRESS_DB → all outputs return to reset values and `rows=4'b1110`. With `KEYPAD_BACKSPACE_EN`, D applied to entry 1,2,3,4 → `0,1,2,3`.
